mem_subsys: RTL and testbench

//   Parametrised memory subsystem between the CPU bus and storage: RAM region plus memory-mapped IO region.

---
 rtl/mem_subsys_pkg.sv | 19 +
 rtl/mem_subsys_ram_bank.sv | 28 ++
 rtl/mem_subsys.sv | 188 ++++++++++++++++++
 tb/tb_mem_subsys.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_subsys_pkg.sv
// Shared types for the memory subsystem: FSM states, decode regions and IO register map.
package mem_subsys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM   = 2'd0,
    RGN_IO    = 2'd1,
    RGN_UNMAP = 2'd2
  } region_e;

  localparam int unsigned IO_LED = 0;
  localparam int unsigned IO_SW  = 1;

endpackage

// File: rtl/mem_subsys_ram_bank.sv
// Single-port synchronous RAM; read data only updates on read cycles so it holds the last RAM read.
module mem_ram_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 15,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or its output register so the block maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_subsys.sv
// Memory subsystem: RAM region plus memory-mapped IO, ready/err handshake, wait states, muxed read path.
module mem_subsys
  import mem_subsys_pkg::*;
#(
  parameter int unsigned     DATA_W       = 8,
  parameter int unsigned     ADDR_W       = 16,
  parameter int unsigned     RAM_AW       = 15,
  parameter int unsigned     RAM_WAIT     = 1,
  parameter int unsigned     NUM_IO       = 4,
  parameter int unsigned     LED_W        = 8,
  parameter logic [LED_W-1:0] LED_INV_MASK = 'h3F,
  parameter                  INIT_FILE    = "data.txt"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              r,
  input  logic              w,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              ready,
  output logic              err,
  input  logic [LED_W-1:0]  sw,
  output logic [LED_W-1:0]  led
);

  localparam int unsigned       IO_IW     = $clog2(NUM_IO);
  localparam logic [ADDR_W-1:0] IO_BASE   = {{(ADDR_W-1){1'b0}}, 1'b1} << RAM_AW;
  localparam logic [3:0]        WAIT_LAST = (RAM_WAIT == 0) ? 4'd0 : 4'(RAM_WAIT - 1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RAM_AW-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              lat_we_q, lat_we_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic              src_ram_q, src_ram_d;
  logic [DATA_W-1:0] io_regs_q [NUM_IO];
  logic [DATA_W-1:0] io_regs_d [NUM_IO];
  logic [LED_W-1:0]  sw_meta_q, sw_meta_d;
  logic [LED_W-1:0]  sw_sync_q, sw_sync_d;

  logic [ADDR_W-1:0] io_off;
  logic [IO_IW-1:0]  io_idx;
  region_e           rgn;
  logic              accept;
  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] rdata;

  assign io_off = addr - IO_BASE;
  assign io_idx = io_off[IO_IW-1:0];
  assign accept = (state_q == ST_IDLE) && ce && (r || w);

  always_comb begin
    rgn = RGN_UNMAP;
    if (addr < IO_BASE)                    rgn = RGN_RAM;
    else if (io_off < ADDR_W'(NUM_IO))     rgn = RGN_IO;
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_we_d   = lat_we_q;
    io_rdata_d = io_rdata_q;
    src_ram_d  = src_ram_q;
    io_regs_d  = io_regs_q;
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = lat_addr_q;
    ram_wdata  = lat_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lat_addr_d = addr[RAM_AW-1:0];
          lat_data_d = in_data;
          lat_we_d   = w;
          if (!(r && w) && rgn == RGN_RAM) begin
            // Zero wait states: the array op rides on the accept edge using the live bus.
            if (RAM_WAIT == 0) begin
              ram_en    = 1'b1;
              ram_we    = w;
              ram_addr  = addr[RAM_AW-1:0];
              ram_wdata = in_data;
              if (!w) src_ram_d = 1'b1;
              state_d   = ST_RESP;
              ready_d   = 1'b1;
            end else begin
              cnt_d   = WAIT_LAST;
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            if ((r && w) || rgn != RGN_IO) begin
              err_d = 1'b1;
              if (r) begin
                io_rdata_d = '0;
                src_ram_d  = 1'b0;
              end
            end else if (r) begin
              src_ram_d  = 1'b0;
              io_rdata_d = (io_idx == IO_IW'(IO_SW)) ? DATA_W'(sw_sync_q) : io_regs_q[io_idx];
            end else if (io_idx != IO_IW'(IO_SW)) begin
              io_regs_d[io_idx] = in_data;
            end
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          ram_en  = 1'b1;
          ram_we  = lat_we_q;
          if (!lat_we_q) src_ram_d = 1'b1;
          state_d = ST_RESP;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_we_q   <= 1'b0;
      io_rdata_q <= '0;
      src_ram_q  <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      for (int unsigned i = 0; i < NUM_IO; i++) io_regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_we_q   <= lat_we_d;
      io_rdata_q <= io_rdata_d;
      src_ram_q  <= src_ram_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      io_regs_q  <= io_regs_d;
    end
  end

  mem_ram_bank #(
    .DATA_W    (DATA_W),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register doubles as read data storage; src_ram_q picks which source is current.
  assign rdata    = src_ram_q ? ram_rdata : io_rdata_q;
  assign out_data = oe ? rdata : '0;
  assign ready    = ready_q;
  assign err      = err_q;
  assign led      = io_regs_q[IO_LED][LED_W-1:0] ^ LED_INV_MASK;

endmodule

// File: tb/tb_mem_subsys.sv
// Directed bench for mem_subsys with an access-level reference model checked every cycle.
module tb_mem_subsys;

  logic        clk = 1'b0;
  logic        rst, ce, r, w, oe;
  logic [15:0] addr;
  logic [7:0]  in_data, out_data, sw, led;
  logic        ready, err;

  always #5 clk = ~clk;

  mem_subsys #(
    .RAM_WAIT  (1),
    .INIT_FILE ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .r        (r),
    .w        (w),
    .oe       (oe),
    .addr     (addr),
    .in_data  (in_data),
    .out_data (out_data),
    .ready    (ready),
    .err      (err),
    .sw       (sw),
    .led      (led)
  );

  int compared   = 0;
  int mismatched = 0;
  int edges      = 0;
  always @(posedge clk) edges++;

  // Reference model: storage contents and outcome of the one access in flight.
  logic [7:0]  m_ram [32768];
  logic [7:0]  m_io  [4];
  logic [7:0]  m_last;
  bit          m_pend;
  int          m_resp_edge;
  logic [15:0] m_a;
  logic [7:0]  m_d;
  bit          m_r, m_w, m_err;
  bit          chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [15:0] a, input bit rd, input bit wr);
    if (rd && wr) return 1;
    if (a < 16'h8000) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_io[i] = 8'h00;
    m_last = 8'h00;
    m_pend = 1'b0;
  endtask

  task automatic model_apply();
    int idx;
    m_err = 1'b0;
    if (m_r && m_w) begin
      m_err  = 1'b1;
      m_last = 8'h00;
    end else if (m_a < 16'h8000) begin
      if (m_w) m_ram[m_a] = m_d;
      else     m_last     = m_ram[m_a];
    end else begin
      idx = m_a - 16'h8000;
      if (idx >= 4) begin
        m_err = 1'b1;
        if (m_r) m_last = 8'h00;
      end else if (idx == 1) begin
        if (m_r) m_last = sw;
      end else if (m_w) begin
        m_io[idx] = m_d;
      end else begin
        m_last = m_io[idx];
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      bit er;
      if (m_pend && edges > m_resp_edge) m_pend = 1'b0;
      er = m_pend && (edges == m_resp_edge);
      if (er) model_apply();
      check("ready", ready, er);
      if (er) check("err", err, m_err);
      check("out_data", out_data, oe ? m_last : 8'h00);
      check("led", led, m_io[0] ^ 8'h3F);
    end
  end

  task automatic access(input logic [15:0] a, input logic [7:0] d, input bit rd, input bit wr,
                        output int lat, output logic [7:0] o, output logic e);
    ce = 1'b1; r = rd; w = wr; addr = a; in_data = d;
    @(posedge clk); #1;
    m_a = a; m_d = d; m_r = rd; m_w = wr;
    m_pend = 1'b1;
    m_resp_edge = edges + lat_of(a, rd, wr) - 1;
    ce = 1'b0; r = 1'($urandom); w = 1'($urandom);
    addr = 16'($urandom); in_data = 8'($urandom);
    lat = 1;
    while (ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    o = out_data;
    e = err;
    @(posedge clk); #1;
  endtask

  initial begin
    int         lat;
    logic [7:0] o;
    logic       e;

    rst = 1'b1; ce = 1'b0; r = 1'b0; w = 1'b0; oe = 1'b1;
    addr = '0; in_data = '0; sw = '0;
    for (int i = 0; i < 32768; i++) m_ram[i] = 8'h00;
    model_reset();
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_led", led, 8'h3F);
    check("rst_ready", ready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_out", out_data, 8'h00);

    access(16'h1234, 8'hA5, 1'b0, 1'b1, lat, o, e);
    check("ram_wr_lat", lat, 2);
    check("ram_wr_err", e, 1'b0);
    access(16'h1234, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("ram_rd_lat", lat, 2);
    check("ram_rd_data", o, 8'hA5);
    check("ram_rd_err", e, 1'b0);

    access(16'h8000, 8'hFF, 1'b0, 1'b1, lat, o, e);
    check("led_wr_lat", lat, 1);
    check("led_value", led, 8'hC0);
    access(16'h8000, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("led_rd_data", o, 8'hFF);

    sw = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    access(16'h8001, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("sw_rd", o, 8'h5A);
    access(16'h8001, 8'h00, 1'b0, 1'b1, lat, o, e);
    check("sw_wr_err", e, 1'b0);
    access(16'h8001, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("sw_reread", o, 8'h5A);

    access(16'h8004, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("unmap_lat", lat, 1);
    check("unmap_err", e, 1'b1);
    check("unmap_data", o, 8'h00);
    access(16'h0010, 8'h33, 1'b0, 1'b1, lat, o, e);
    access(16'h0010, 8'h99, 1'b1, 1'b1, lat, o, e);
    check("rw_lat", lat, 1);
    check("rw_err", e, 1'b1);
    access(16'h0010, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("rw_ram_kept", o, 8'h33);

    access(16'h7FFF, 8'h4C, 1'b0, 1'b1, lat, o, e);
    access(16'h8003, 8'h3C, 1'b0, 1'b1, lat, o, e);
    access(16'h8002, 8'hE1, 1'b0, 1'b1, lat, o, e);
    access(16'h7FFF, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("ram_top", o, 8'h4C);
    access(16'h8003, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("io3_rd", o, 8'h3C);
    access(16'hFFFF, 8'h12, 1'b0, 1'b1, lat, o, e);
    check("ffff_err", e, 1'b1);
    access(16'h8003, 8'h3C, 1'b0, 1'b1, lat, o, e);
    oe = 1'b0;
    @(posedge clk); #1;
    check("oe_low", out_data, 8'h00);
    oe = 1'b1;
    @(posedge clk); #1;
    check("oe_hold", out_data, 8'h3C);

    access(16'h0020, 8'h11, 1'b0, 1'b1, lat, o, e);
    ce = 1'b1; r = 1'b0; w = 1'b1; addr = 16'h0020; in_data = 8'h77;
    @(posedge clk); #1;
    ce = 1'b0; w = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 check("rst_busy_ready", ready, 1'b0);
    @(posedge clk); #1;
    check("rst_busy_ready2", ready, 1'b0);
    rst = 1'b0;
    check("rst_busy_led", led, 8'h3F);
    @(posedge clk); #1;
    access(16'h0020, 8'h00, 1'b1, 1'b0, lat, o, e);
    check("rst_idle_lat", lat, 2);
    check("rst_no_commit", o, 8'h11);

    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL timeout: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
